// File: rtl/vga_layer_mixer.sv
// VGA timing generator with a fixed-priority mixer for 1-bit overlay layers.
// Define VGA_MIXER_BLINK_EN to build the alarm-driven blinking of masked layers.
module vga_layer_mixer #(
    parameter int unsigned NUM_LAYERS   = 5,
    parameter int unsigned PIX_DIV      = 4,
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned H_FP         = 16,
    parameter int unsigned H_SYNC       = 96,
    parameter int unsigned H_BP         = 48,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned V_FP         = 10,
    parameter int unsigned V_SYNC       = 2,
    parameter int unsigned V_BP         = 33,
    parameter int unsigned LAYER_LAT    = 2,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic                     reloj,
    input  logic                     resetM,
    input  logic [NUM_LAYERS-1:0]    layer_bits,
    input  logic [NUM_LAYERS-1:0]    layer_en,
    input  logic [12*NUM_LAYERS-1:0] layer_color,
    input  logic [11:0]              bg_color,
    input  logic                     bit_alarma,
    input  logic [NUM_LAYERS-1:0]    blink_mask,
    output logic [9:0]               Qh,
    output logic [9:0]               Qv,
    output logic                     pix_tick,
    output logic                     frame_start,
    output logic                     H_Syncreg,
    output logic                     V_Syncreg,
    output logic [3:0]               R,
    output logic [3:0]               G,
    output logic [3:0]               B
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_LO = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_HI = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_LO = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_HI = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Sync flags are carried as "in sync pulse" so a cleared pipeline means syncs idle high.
    typedef struct packed {
        logic vs_on;
        logic hs_on;
        logic active;
    } timing_t;

    logic [DIV_W-1:0]      div_q, div_d;
    logic [9:0]            qh_q, qh_d;
    logic [9:0]            qv_q, qv_d;
    timing_t               raw_t;
    timing_t               dly_t;
    logic [NUM_LAYERS-1:0] blink_hide;
    logic [NUM_LAYERS-1:0] visible;
    logic [11:0]           pix_color;
    logic [11:0]           rgb_q;
    logic                  hsync_q;
    logic                  vsync_q;

    // ---------------------------------------------------------------- pixel clock and counters
    assign pix_tick    = (div_q == DIV_LAST);
    assign frame_start = pix_tick && (qh_q == H_LAST) && (qv_q == V_LAST);

    always_comb begin
        div_d = div_q + 1'b1;
        qh_d  = qh_q;
        qv_d  = qv_q;
        if (pix_tick) begin
            div_d = '0;
            if (qh_q == H_LAST) begin
                qh_d = '0;
                qv_d = (qv_q == V_LAST) ? 10'd0 : qv_q + 10'd1;
            end else begin
                qh_d = qh_q + 10'd1;
            end
        end
    end

    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            div_q <= '0;
            qh_q  <= '0;
            qv_q  <= '0;
        end else begin
            div_q <= div_d;
            qh_q  <= qh_d;
            qv_q  <= qv_d;
        end
    end

    assign Qh = qh_q;
    assign Qv = qv_q;

    // ---------------------------------------------------------------- raw timing decode
    always_comb begin
        raw_t.active = (qh_q < H_ACT) && (qv_q < V_ACT);
        raw_t.hs_on  = (qh_q >= H_SYNC_LO) && (qh_q <= H_SYNC_HI);
        raw_t.vs_on  = (qv_q >= V_SYNC_LO) && (qv_q <= V_SYNC_HI);
    end

    // ---------------------------------------------------------------- alignment with layer_bits
    if (LAYER_LAT == 0) begin : g_no_delay
        assign dly_t = raw_t;
    end else begin : g_delay
        timing_t dly_q [LAYER_LAT];

        always_ff @(posedge reloj or negedge resetM) begin
            if (!resetM) begin
                for (int i = 0; i < int'(LAYER_LAT); i++) begin
                    dly_q[i] <= '0;
                end
            end else if (pix_tick) begin
                dly_q[0] <= raw_t;
                for (int i = 1; i < int'(LAYER_LAT); i++) begin
                    dly_q[i] <= dly_q[i-1];
                end
            end
        end

        assign dly_t = dly_q[LAYER_LAT-1];
    end

    // ---------------------------------------------------------------- blink control
`ifdef VGA_MIXER_BLINK_EN
    localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_on_q, phase_on_d;
    logic               alarm_q;

    // A falling alarm edge takes priority over a coincident frame_start.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_on_d  = phase_on_q;
        if (alarm_q && !bit_alarma) begin
            blink_cnt_d = '0;
            phase_on_d  = 1'b1;
        end else if (frame_start) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                phase_on_d  = !phase_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            blink_cnt_q <= '0;
            phase_on_q  <= 1'b1;
            alarm_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_on_q  <= phase_on_d;
            alarm_q     <= bit_alarma;
        end
    end

    assign blink_hide = (bit_alarma && !phase_on_q) ? blink_mask : '0;
`else
    logic unused_blink;
    assign unused_blink = ^{bit_alarma, blink_mask};
    assign blink_hide   = '0;
`endif

    // ---------------------------------------------------------------- priority mixer
    // Scanning from the top index down leaves the lowest visible index as the winner.
    always_comb begin
        visible   = layer_bits & layer_en & ~blink_hide;
        pix_color = bg_color;
        for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
            if (visible[i]) begin
                pix_color = layer_color[12*i +: 12];
            end
        end
        if (!dly_t.active) begin
            pix_color = '0;
        end
    end

    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            rgb_q   <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else if (pix_tick) begin
            rgb_q   <= pix_color;
            hsync_q <= !dly_t.hs_on;
            vsync_q <= !dly_t.vs_on;
        end
    end

    assign H_Syncreg = hsync_q;
    assign V_Syncreg = vsync_q;
    assign R         = rgb_q[11:8];
    assign G         = rgb_q[7:4];
    assign B         = rgb_q[3:0];

endmodule
